regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width (2^ADDRESS_WIDTH registers).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, secondary writeback buffer entries.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, consecutive primary wins before a forced drain.
REQ-005 SHALL have ports: clk input 1, the single clock; rst input 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: p_wr_en input 1, primary pipeline writeback valid; p_wr_dest input ADDRESS_WIDTH; p_wr_data input DATA_WIDTH.
REQ-007 SHALL have ports: s_valid input 1, long-latency unit result valid; s_dest input ADDRESS_WIDTH; s_data input DATA_WIDTH; s_ready output 1, buffer can accept.
REQ-008 SHALL have ports: iss_valid input 1, long-latency op issue; iss_dest input ADDRESS_WIDTH; iss_ready output 1, issue accepted.
REQ-009 SHALL have ports: rd_addr1, rd_addr2 input ADDRESS_WIDTH, decode read addresses; hz1, hz2 output 1, pending-write hazard per read address.
REQ-010 SHALL have ports: pipe_stall output 1, primary writeback must idle next cycle.
REQ-011 SHALL have ports: rg_wrt_en output 1, rg_wrt_dest output ADDRESS_WIDTH, rg_wrt_data output DATA_WIDTH; these drive the register file write port.

Function
REQ-012 SHALL register rg_wrt_en/dest/data on posedge clk; the register file captures them on the following negedge.
REQ-013 SHALL grant the write port each cycle: p_wr_en=1 -> primary; else FIFO non-empty -> FIFO head, popped that cycle; else rg_wrt_en=0.
REQ-014 SHALL suppress any write with dest 0 (rg_wrt_en=0); a suppressed FIFO entry is still popped.
REQ-015 SHALL push {s_dest,s_data} on s_valid && s_ready; s_ready = (count < FIFO_DEPTH), combinational from registered count.
REQ-016 SHALL update the FIFO on simultaneous push and pop with count unchanged; order SHALL be strictly FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL keep a starve counter: increment when the primary wins with the FIFO non-empty; clear on any FIFO pop or when the FIFO is empty; saturate at STARVE_LIMIT.
REQ-018 SHALL assert pipe_stall (registered) for exactly one cycle when the starve counter reaches STARVE_LIMIT, then clear the counter.
REQ-019 SHALL require p_wr_en=0 in the cycle pipe_stall=1, which forces a pop; p_wr_en=1 in that cycle is a protocol violation and primary still wins.
REQ-020 SHALL keep a 2^ADDRESS_WIDTH busy vector; iss_ready = !busy[iss_dest] || iss_dest==0; busy[iss_dest] set on iss_valid && iss_ready && iss_dest!=0.
REQ-021 SHALL clear busy[d] when a FIFO entry with dest d is popped; a same-cycle set of the same d wins over the clear.
REQ-022 SHALL leave busy unaffected by primary writes.
REQ-023 SHALL drive hz1 = busy[rd_addr1] and hz2 = busy[rd_addr2] combinationally; address 0 always yields 0.

Reset
REQ-024 SHALL on rst=0, asynchronously: rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, pipe_stall=0, FIFO empty, pointers 0, starve counter 0, busy all 0.
REQ-025 SHALL drive s_ready=0 while rst=0 and s_ready=1 from the first clock after release.
REQ-026 SHALL discard FIFO contents and pending busy bits when reset is asserted mid-operation; no partial write SHALL follow reset release.

Verification
REQ-027 Primary only: p_wr_en=1, dest 5, data 0xDEADBEEF -> next cycle rg_wrt_en=1, rg_wrt_dest=5, rg_wrt_data=0xDEADBEEF.
REQ-028 Issue/complete: iss dest 7, then s push {7,0x12} with p_wr_en=0 -> hz1=1 while rd_addr1=7; write of 0x12 to 7 lands; busy[7] clears the same edge; hz1=0 afterward.
REQ-029 Full buffer: p_wr_en=1 continuous, two s pushes -> s_ready=0; pipe_stall pulses after 4 primary wins; the stall cycle writes FIFO head; s_ready returns to 1.
REQ-030 Dest 0 and busy reissue: s push to dest 0 -> popped, rg_wrt_en=0. iss dest 3 twice with no completion -> second iss_ready=0.
REQ-031 Simultaneous pop and reissue of dest 9 -> busy[9] remains 1.
REQ-032 Mid-operation reset: rst=0 with 2 FIFO entries and busy bits set -> all outputs 0 immediately; after release s_ready=1, hz1=hz2=0, no spurious write.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the primary pipeline writeback wins the port, and
// long-latency results queue in a small FIFO, with a forced drain and a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_wr_en,
  input  logic [ADDRESS_WIDTH-1:0] p_wr_dest,
  input  logic [DATA_WIDTH-1:0]    p_wr_data,
  input  logic                     s_valid,
  input  logic [ADDRESS_WIDTH-1:0] s_dest,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     s_ready,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_dest,
  output logic                     iss_ready,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr1,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr2,
  output logic                     hz1,
  output logic                     hz2,
  output logic                     pipe_stall,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data
);

  localparam int NREG  = 1 << ADDRESS_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDRESS_WIDTH-1:0] fifo_dest_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_dest_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [STV_W-1:0]         starve_q, starve_d;
  logic [STV_W-1:0]         starve_inc;
  logic                     pipe_stall_q, pipe_stall_d;
  logic                     alive_q;
  logic [NREG-1:0]          busy_q, busy_d;
  logic                     rg_wrt_en_q, rg_wrt_en_d;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_q, rg_wrt_dest_d;
  logic [DATA_WIDTH-1:0]    rg_wrt_data_q, rg_wrt_data_d;

  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic [ADDRESS_WIDTH-1:0] head_dest;
  logic [DATA_WIDTH-1:0]    head_data;

  // alive_q holds s_ready low until the first clock edge after reset release
  assign s_ready   = alive_q && (count_q < CNT_W'(FIFO_DEPTH));
  assign iss_ready = !busy_q[iss_dest] || (iss_dest == '0);
  assign hz1       = busy_q[rd_addr1] && (rd_addr1 != '0);
  assign hz2       = busy_q[rd_addr2] && (rd_addr2 != '0);

  assign pipe_stall  = pipe_stall_q;
  assign rg_wrt_en   = rg_wrt_en_q;
  assign rg_wrt_dest = rg_wrt_dest_q;
  assign rg_wrt_data = rg_wrt_data_q;

  always_comb begin
    fifo_empty    = (count_q == '0);
    push          = s_valid && s_ready;
    pop           = !p_wr_en && !fifo_empty;
    head_dest     = fifo_dest_q[rd_ptr_q];
    head_data     = fifo_data_q[rd_ptr_q];
    fifo_dest_d   = fifo_dest_q;
    fifo_data_d   = fifo_data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    starve_d      = starve_q;
    starve_inc    = starve_q;
    pipe_stall_d  = 1'b0;
    busy_d        = busy_q;
    rg_wrt_en_d   = 1'b0;
    rg_wrt_dest_d = rg_wrt_dest_q;
    rg_wrt_data_d = rg_wrt_data_q;

    if (push) begin
      fifo_dest_d[wr_ptr_q] = s_dest;
      fifo_data_d[wr_ptr_q] = s_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Dest 0 is the hardwired zero register: the slot is consumed but nothing is written
    if (p_wr_en) begin
      rg_wrt_en_d   = (p_wr_dest != '0);
      rg_wrt_dest_d = p_wr_dest;
      rg_wrt_data_d = p_wr_data;
    end else if (pop) begin
      rg_wrt_en_d   = (head_dest != '0);
      rg_wrt_dest_d = head_dest;
      rg_wrt_data_d = head_data;
    end

    // The stall is raised on the edge the counter reaches the limit, so the counter restarts there
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (p_wr_en) begin
      starve_inc = (starve_q < STV_W'(STARVE_LIMIT)) ? starve_q + STV_W'(1) : starve_q;
      if (starve_inc == STV_W'(STARVE_LIMIT)) begin
        pipe_stall_d = 1'b1;
        starve_d     = '0;
      end else begin
        starve_d = starve_inc;
      end
    end

    // A same-cycle issue to the popped dest must leave it busy, so the set is applied last
    if (pop) begin
      busy_d[head_dest] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_dest != '0)) begin
      busy_d[iss_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_dest_q   <= '{default: '0};
      fifo_data_q   <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      starve_q      <= '0;
      pipe_stall_q  <= 1'b0;
      alive_q       <= 1'b0;
      busy_q        <= '0;
      rg_wrt_en_q   <= 1'b0;
      rg_wrt_dest_q <= '0;
      rg_wrt_data_q <= '0;
    end else begin
      fifo_dest_q   <= fifo_dest_d;
      fifo_data_q   <= fifo_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      starve_q      <= starve_d;
      pipe_stall_q  <= pipe_stall_d;
      alive_q       <= 1'b1;
      busy_q        <= busy_d;
      rg_wrt_en_q   <= rg_wrt_en_d;
      rg_wrt_dest_q <= rg_wrt_dest_d;
      rg_wrt_data_q <= rg_wrt_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a write-port scoreboard fed by a small FIFO model, plus
// per-scenario inline checks of hazards, readiness and stall.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  dest;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_wr_en = 1'b0;
  logic [4:0]  p_wr_dest = '0;
  logic [31:0] p_wr_data = '0;
  logic        s_valid = 1'b0;
  logic [4:0]  s_dest = '0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_dest = '0;
  logic        iss_ready;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        hz1, hz2;
  logic        pipe_stall;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mq[$];

  regfile_wb_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .p_wr_en(p_wr_en), .p_wr_dest(p_wr_dest), .p_wr_data(p_wr_data),
    .s_valid(s_valid), .s_dest(s_dest), .s_data(s_data), .s_ready(s_ready),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hz1(hz1), .hz2(hz2),
    .pipe_stall(pipe_stall),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: each driven cycle expects one write-port result after the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (rg_wrt_en !== e.en || (e.en && (rg_wrt_dest !== e.dest || rg_wrt_data !== e.data))) begin
          n_fail++;
          $display("FAIL wr_port cyc=%0d got en=%b dest=%0d data=%h expected en=%b dest=%0d data=%h",
                   cyc, rg_wrt_en, rg_wrt_dest, rg_wrt_data, e.en, e.dest, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drives one cycle at the falling edge and records what the write port must show after it
  task automatic drive(input logic pe, input logic [4:0] pd, input logic [31:0] pdat,
                       input logic sv, input logic [4:0] sd, input logic [31:0] sdat,
                       input logic iv, input logic [4:0] id);
    exp_t e;
    exp_t m;
    int   pre;
    @(negedge clk);
    p_wr_en = pe; p_wr_dest = pd; p_wr_data = pdat;
    s_valid = sv; s_dest = sd; s_data = sdat;
    iss_valid = iv; iss_dest = id;
    pre = mq.size();
    e = '0;
    e.due = cyc + 1;
    if (pe) begin
      e.en = (pd != 0); e.dest = pd; e.data = pdat;
    end else if (pre > 0) begin
      m = mq.pop_front();
      e.en = (m.dest != 0); e.dest = m.dest; e.data = m.data;
    end
    exp_q.push_back(e);
    if (sv && pre < 2) begin
      m = '0; m.dest = sd; m.data = sdat;
      mq.push_back(m);
    end
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd0 || rg_wrt_data !== 32'd0 || pipe_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b dest=%0d data=%h stall=%b expected all 0",
               rg_wrt_en, rg_wrt_dest, rg_wrt_data, pipe_stall);
    end
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_s_ready got %b expected 0", s_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL release_s_ready_pre_edge got %b expected 0", s_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s_ready !== 1'b1 || hz1 !== 1'b0 || hz2 !== 1'b0) begin
      n_fail++; $display("FAIL release_first_edge got s_ready=%b hz1=%b hz2=%b expected 1 0 0", s_ready, hz1, hz2);
    end
  endtask

  task automatic test_primary();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    drive(1, 5'd12, 32'h0BADF00D, 0, 0, 0, 0, 0);
    drive(1, 5'd31, 32'h00000001, 0, 0, 0, 0, 0);
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic test_issue_complete();
    rd_addr1 = 5'd7;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL iss7_ready got %b expected 1", iss_ready);
    end
    drive(0, 0, 0, 1, 5'd7, 32'h12, 0, 0);
    n_checks++;
    if (hz1 !== 1'b1) begin
      n_fail++; $display("FAIL hz1_busy7 got %b expected 1", hz1);
    end
    idle();
    n_checks++;
    if (hz1 !== 1'b1) begin
      n_fail++; $display("FAIL hz1_pop_cycle got %b expected 1", hz1);
    end
    idle();
    n_checks++;
    if (hz1 !== 1'b0) begin
      n_fail++; $display("FAIL hz1_cleared got %b expected 0", hz1);
    end
    rd_addr1 = 5'd0;
  endtask

  task automatic test_full_buffer();
    logic [2:0] stall_exp [8];
    stall_exp[0] = 0; stall_exp[1] = 0; stall_exp[2] = 0; stall_exp[3] = 0;
    stall_exp[4] = 0; stall_exp[5] = 1; stall_exp[6] = 0; stall_exp[7] = 0;
    drive(1, 5'd1, 32'hA1, 1, 5'd10, 32'h100, 0, 0);
    drive(1, 5'd2, 32'hA2, 1, 5'd11, 32'h101, 0, 0);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL fifo_one_entry_ready got %b expected 1", s_ready);
    end
    for (int k = 2; k < 8; k++) begin
      if (k < 5) drive(1, 5'(k + 1), 32'hA0 + 32'(k + 1), 0, 0, 0, 0, 0);
      else       idle();
      n_checks++;
      if (pipe_stall !== stall_exp[k][0]) begin
        n_fail++; $display("FAIL stall_cycle%0d got %b expected %b", k, pipe_stall, stall_exp[k][0]);
      end
      if (k == 2) begin
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++; $display("FAIL fifo_full_ready got %b expected 0", s_ready);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (s_ready !== 1'b1) begin
          n_fail++; $display("FAIL fifo_after_drain_ready got %b expected 1", s_ready);
        end
      end
    end
  endtask

  task automatic test_dest0_reissue();
    drive(0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
    idle();
    rd_addr2 = 5'd3;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd3);
    n_checks++;
    if (iss_ready !== 1'b1 || hz2 !== 1'b0) begin
      n_fail++; $display("FAIL iss3_first got ready=%b hz2=%b expected 1 0", iss_ready, hz2);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5'd3);
    n_checks++;
    if (iss_ready !== 1'b0 || hz2 !== 1'b1) begin
      n_fail++; $display("FAIL iss3_second got ready=%b hz2=%b expected 0 1", iss_ready, hz2);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL iss0_ready got %b expected 1", iss_ready);
    end
    rd_addr1 = 5'd0;
    idle();
    n_checks++;
    if (hz1 !== 1'b0) begin
      n_fail++; $display("FAIL hz_addr0 got %b expected 0", hz1);
    end
  endtask

  task automatic test_pop_reissue();
    rd_addr1 = 5'd9;
    drive(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
    n_checks++;
    if (hz1 !== 1'b0) begin
      n_fail++; $display("FAIL hz9_before got %b expected 0", hz1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL iss9_ready got %b expected 1", iss_ready);
    end
    idle();
    n_checks++;
    if (hz1 !== 1'b1) begin
      n_fail++; $display("FAIL busy9_set_wins got hz1=%b expected 1", hz1);
    end
  endtask

  task automatic test_mid_reset();
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd6;
    drive(1, 5'd1, 32'hB1, 1, 5'd20, 32'h200, 1, 5'd4);
    drive(1, 5'd2, 32'hB2, 1, 5'd21, 32'h201, 1, 5'd6);
    drive(1, 5'd3, 32'hB3, 0, 0, 0, 0, 0);
    n_checks++;
    if (hz1 !== 1'b1 || hz2 !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset_state got hz1=%b hz2=%b s_ready=%b expected 1 1 0", hz1, hz2, s_ready);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    mq.delete();
    p_wr_en = 0; s_valid = 0; iss_valid = 0;
    #1;
    n_checks++;
    if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd0 || rg_wrt_data !== 32'd0 || pipe_stall !== 1'b0 ||
        s_ready !== 1'b0 || hz1 !== 1'b0 || hz2 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got en=%b dest=%0d data=%h stall=%b s_ready=%b hz1=%b hz2=%b expected all 0",
               rg_wrt_en, rg_wrt_dest, rg_wrt_data, pipe_stall, s_ready, hz1, hz2);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_release_pre_edge got s_ready=%b expected 0", s_ready);
    end
    idle();
    n_checks++;
    if (s_ready !== 1'b1 || hz1 !== 1'b0 || hz2 !== 1'b0 || rg_wrt_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_release_state got s_ready=%b hz1=%b hz2=%b en=%b expected 1 0 0 0",
                         s_ready, hz1, hz2, rg_wrt_en);
    end
    idle();
    idle();
  endtask

  initial begin
    test_reset();
    test_primary();
    test_issue_complete();
    test_full_buffer();
    test_dest0_reissue();
    test_pop_reissue();
    test_mid_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drained got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
